// File: rtl/uart_rx_frame_pkg.sv
// Shared types for the UART receive path.
// State encoding and data width used by uart_rx_frame.
package soc2_uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BRK    = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Byte handshake between the RX framer and the register block.
// Producer drives data/valid, consumer drives ready.
interface uart_rx_frame_if;
  import soc2_uart_pkg::*;

  logic [UART_DATA_BITS-1:0] rx_data_o;
  logic                      rx_valid_o;
  logic                      rx_ready_i;

  modport master (
    output rx_data_o,
    output rx_valid_o,
    input  rx_ready_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_valid_o,
    output rx_ready_i
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the RX pad plus a falling-edge detect.
// All flops reset to the idle-high line level.
module uart_rx_sync (
  input  logic clk,
  input  logic resetn,
  input  logic rx_i,
  output logic rx_s,
  output logic rx_fall
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      prev_q <= sync_q[1];
    end
  end

  assign rx_s    = sync_q[1];
  assign rx_fall = prev_q & ~sync_q[1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive framer: start validation, mid-bit sampling, stop check.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data.
module uart_rx_frame
  import soc2_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217,
  parameter int CNT_W        = 16
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            rx_i,
  uart_rx_frame_if.master rx,
  output logic            frame_err_o,
  output logic            overrun_o,
  output logic            parity_err_o,
  output logic            busy_o
);

  localparam logic [CNT_W-1:0] HALF =
    CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT =
    3'(UART_DATA_BITS - 1);

  logic rx_s;
  logic rx_fall;

  uart_rx_sync u_sync (
    .clk     (clk),
    .resetn  (resetn),
    .rx_i    (rx_i),
    .rx_s    (rx_s),
    .rx_fall (rx_fall)
  );

  rx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      ferr_q;
  logic                      ovr_q;
  logic                      cnt_zero;
  logic                      stop_smp;
  logic                      accept;
  logic                      ferr_d;
  logic                      par_bad;
  logic                      fire;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q;
`endif

  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      ovr_q   <= accept & valid_q & ~fire;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= stop_smp & par_bad;
`endif
      // A same-cycle handshake frees the holder for the new byte
      if (accept && (!valid_q || fire)) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (fire) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_d = START;
          cnt_d   = HALF;
        end
      end
      START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d = DATA;
          cnt_d   = FULL;
          bit_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL;
          if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_d   = rx_s;
          cnt_d   = FULL;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = rx_s ? IDLE : BRK;
        end
      end
      BRK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
`ifdef UART_RX_PARITY_EN
    par_bad = ^{shift_q, par_q};
`else
    par_bad = 1'b0;
`endif
    stop_smp = (state_q == STOP) && cnt_zero;
    accept   = stop_smp && rx_s && !par_bad;
    ferr_d   = stop_smp && !rx_s;
    fire     = valid_q && rx.rx_ready_i;
    busy_o   = (state_q != IDLE);
  end

  assign rx.rx_data_o  = data_q;
  assign rx.rx_valid_o = valid_q;
  assign frame_err_o   = ferr_q;
  assign overrun_o     = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o  = perr_q;
`else
  assign parity_err_o  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame at 8 clocks per bit.
// Build with UART_RX_PARITY_EN to cover the parity variant.
module tb_uart_rx_frame;
  import soc2_uart_pkg::*;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  // pin fall -> START entry 3 edges, half bit to start sample,
  // then data (+parity) and stop bits at full-bit spacing
  localparam int LAT = 3 + CPB / 2 + (9 + PB) * CPB;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic rx_i = 1'b1;
  logic ferr, ovr, perr, busy;

  uart_rx_frame_if bus ();

  uart_rx_frame #(
    .CLKS_PER_BIT (CPB),
    .CNT_W        (16)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rx_i         (rx_i),
    .rx           (bus.master),
    .frame_err_o  (ferr),
    .overrun_o    (ovr),
    .parity_err_o (perr),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int ferr_exp = 0, ovr_exp = 0, perr_exp = 0;
  int ferr_obs = 0, ovr_obs = 0, perr_obs = 0;
  int vrise_cyc = 0;
  int vhigh_cnt = 0;
  logic v_prev = 0, f_prev = 0, o_prev = 0, p_prev = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input bit stop_ok,
                            input bit par_ok);
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(CPB);
    end
    if (PB != 0) begin
      rx_i = (^b) ^ !par_ok;
      tick(CPB);
    end
    rx_i = stop_ok;
    tick(CPB);
  endtask

  // reference outcome of one frame with the holder free
  task automatic expect_frame(input logic [7:0] b,
                              input bit stop_ok,
                              input bit par_ok);
    bit pbad;
    pbad = (PB != 0) && !par_ok;
    if (!stop_ok) ferr_exp++;
    if (pbad) perr_exp++;
    if (stop_ok && !pbad) exp_q.push_back(b);
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      v_prev = 0; f_prev = 0; o_prev = 0; p_prev = 0;
    end else begin
      if (bus.rx_valid_o) vhigh_cnt++;
      if (bus.rx_valid_o && !v_prev) vrise_cyc = cyc;
      if (bus.rx_valid_o && bus.rx_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL byte_unexpected: got %0h expected none",
                   bus.rx_data_o);
        end else begin
          chk("byte", 32'(bus.rx_data_o), 32'(exp_q.pop_front()));
        end
      end
      if (ferr) begin
        ferr_obs++;
        chk("ferr_width", 32'(f_prev), 0);
      end
      if (ovr) begin
        ovr_obs++;
        chk("ovr_width", 32'(o_prev), 0);
      end
      if (perr) begin
        perr_obs++;
        chk("perr_width", 32'(p_prev), 0);
      end
      v_prev = bus.rx_valid_o;
      f_prev = ferr;
      o_prev = ovr;
      p_prev = perr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n0, vh0;
    logic [7:0] b;
    bit s_ok, p_ok;

    bus.rx_ready_i = 1'b1;
    tick(3);
    chk("rst_valid", 32'(bus.rx_valid_o), 0);
    chk("rst_data", 32'(bus.rx_data_o), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs", {29'd0, ferr, ovr, perr}, 0);
    resetn = 1'b1;
    tick(5);

    // single clean frame, latency and valid width
    vh0 = vhigh_cnt;
    expect_frame(8'h5A, 1, 1);
    n0 = cyc;
    send_frame(8'h5A, 1, 1);
    tick(4);
    chk("t1_latency", 32'(vrise_cyc - n0), 32'(LAT));
    chk("t1_valid_cycles", 32'(vhigh_cnt - vh0), 1);
    chk("t1_no_err", 32'(ferr_obs + ovr_obs + perr_obs), 0);

    // short low glitch rejected at the start sample
    rx_i = 1'b0;
    tick(3);
    chk("t2_busy_start", 32'(busy), 1);
    rx_i = 1'b1;
    tick(12);
    chk("t2_busy_idle", 32'(busy), 0);
    chk("t2_no_ferr", 32'(ferr_obs), 0);

    // stop bit low, line held low (break)
    expect_frame(8'h00, 0, 1);
    send_frame(8'h00, 0, 1);
    tick(32);
    chk("t3_busy_brk", 32'(busy), 1);
    chk("t3_ferr", 32'(ferr_obs), 32'(ferr_exp));
    rx_i = 1'b1;
    tick(5);
    chk("t3_busy_idle", 32'(busy), 0);

    // two frames with no consumer -> overrun on the second
    bus.rx_ready_i = 1'b0;
    expect_frame(8'h11, 1, 1);
    send_frame(8'h11, 1, 1);
    send_frame(8'h22, 1, 1);
    ovr_exp++;
    tick(3);
    chk("t4_hold_data", 32'(bus.rx_data_o), 32'h11);
    chk("t4_hold_valid", 32'(bus.rx_valid_o), 1);
    chk("t4_ovr", 32'(ovr_obs), 32'(ovr_exp));
    bus.rx_ready_i = 1'b1;
    tick(1);
    bus.rx_ready_i = 1'b0;
    tick(1);
    chk("t4_valid_drop", 32'(bus.rx_valid_o), 0);
    bus.rx_ready_i = 1'b1;

    // reset pulse during data bit 3
    rx_i = 1'b0;
    tick(CPB);
    rx_i = 1'b1;
    tick(3 * CPB + CPB / 2);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    chk("t5_rst_data", 32'(bus.rx_data_o), 0);
    chk("t5_rst_valid", 32'(bus.rx_valid_o), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    tick(20);
    expect_frame(8'hA5, 1, 1);
    send_frame(8'hA5, 1, 1);
    tick(4);
    chk("t5_rx_after_rst", 32'(exp_q.size()), 0);

`ifdef UART_RX_PARITY_EN
    expect_frame(8'h07, 1, 0);
    send_frame(8'h07, 1, 0);
    tick(4);
    chk("t6_perr", 32'(perr_obs), 32'(perr_exp));
    expect_frame(8'h07, 1, 1);
    send_frame(8'h07, 1, 1);
    tick(4);
    chk("t6_good", 32'(exp_q.size()), 0);
`endif

    // randomized frames, stop and parity errors mixed in
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom);
      s_ok = ($urandom_range(0, 5) != 0);
      p_ok = ($urandom_range(0, 3) != 0);
      expect_frame(b, s_ok, p_ok);
      send_frame(b, s_ok, p_ok);
      rx_i = 1'b1;
      tick($urandom_range(1, 12));
    end
    tick(30);

    chk("end_queue_empty", 32'(exp_q.size()), 0);
    chk("end_ferr", 32'(ferr_obs), 32'(ferr_exp));
    chk("end_ovr", 32'(ovr_obs), 32'(ovr_exp));
    chk("end_perr", 32'(perr_obs), 32'(perr_exp));
    chk("end_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
